// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer for the binary number game.
//
// Picks a fresh 4-bit target for every round from a free-running LFSR,
// runs a per-round countdown, scores correct submissions and takes a life
// on a wrong submission or a timeout. Sequence: idle -> rounds -> game over.
//
// Parameters:
//   TICK_DIV   clock cycles per countdown second (>= 2)
//   ROUND_TIME seconds per round (1..15)
//   LIVES      lives at game start (1..3)
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   start_btn   debounced, synchronised start button level
//   submit_btn  debounced, synchronised submit button level
//   match       comparator result: player switches equal target
//   target      number to display and compare against
//   score       rounds won, saturating at 255
//   lives       remaining lives
//   time_left   seconds left in the current round
//   playing     high while a round is running
//   round_won   one-cycle pulse after a correct submit
//   game_over   high once all lives are spent
module game_round_ctrl #(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned ROUND_TIME = 10,
    parameter int unsigned LIVES      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       submit_btn,
    input  logic       match,
    output logic [3:0] target,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [3:0] time_left,
    output logic       playing,
    output logic       round_won,
    output logic       game_over
);

    localparam int unsigned     CntW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax    = CntW'(TICK_DIV - 1);
    localparam logic [3:0]      RoundTime = 4'(ROUND_TIME);
    localparam logic [1:0]      LivesInit = 2'(LIVES);

    typedef enum logic [2:0] {
        StIdle,
        StNewRound,
        StPlay,
        StResult,
        StOver
    } state_e;

    state_e          state_q, state_d;
    logic            start_q, submit_q;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      target_q, target_d;
    logic [7:0]      score_q, score_d;
    logic [1:0]      lives_q, lives_d;
    logic [3:0]      time_q, time_d;
    logic            won_q, won_d;

    logic start_e;
    logic submit_e;
    logic tick;

    // Edge registers reset high so a button held through reset gives no edge.
    assign start_e  = start_btn & ~start_q;
    assign submit_e = submit_btn & ~submit_q;
    assign tick     = (cnt_q == CntMax);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            start_q  <= 1'b1;
            submit_q <= 1'b1;
            lfsr_q   <= 8'hA5;
            cnt_q    <= '0;
            target_q <= 4'd0;
            score_q  <= 8'd0;
            lives_q  <= 2'd0;
            time_q   <= 4'd0;
            won_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_btn;
            submit_q <= submit_btn;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            time_q   <= time_d;
            won_q    <= won_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        score_d  = score_q;
        lives_d  = lives_q;
        time_d   = time_q;
        won_d    = 1'b0;
        // Taps 7,5,4,3: maximal length, so the all-zero state is never reached.
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        unique case (state_q)
            StIdle, StOver: begin
                if (start_e) begin
                    score_d = 8'd0;
                    lives_d = LivesInit;
                    state_d = StNewRound;
                end
            end
            StNewRound: begin
                // Bump by one on a repeat so the player always sees a change.
                if (lfsr_q[3:0] == target_q) begin
                    target_d = lfsr_q[3:0] + 4'd1;
                end else begin
                    target_d = lfsr_q[3:0];
                end
                time_d  = RoundTime;
                cnt_d   = '0;
                state_d = StPlay;
            end
            StPlay: begin
                cnt_d = tick ? '0 : cnt_q + CntW'(1);
                // Submit wins over a coincident tick and freezes the countdown.
                if (submit_e) begin
                    if (match) begin
                        if (score_q != 8'hFF) begin
                            score_d = score_q + 8'd1;
                        end
                        won_d = 1'b1;
                    end else begin
                        lives_d = lives_q - 2'd1;
                    end
                    state_d = StResult;
                end else if (tick) begin
                    if (time_q == 4'd1) begin
                        time_d  = 4'd0;
                        lives_d = lives_q - 2'd1;
                        state_d = StResult;
                    end else begin
                        time_d = time_q - 4'd1;
                    end
                end
            end
            StResult: begin
                state_d = (lives_q == 2'd0) ? StOver : StNewRound;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign target    = target_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign time_left = time_q;
    assign playing   = (state_q == StPlay);
    assign round_won = won_q;
    assign game_over = (state_q == StOver);

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl with TICK_DIV=4, ROUND_TIME=3, LIVES=2.
// A cycle-level behavioural model of the game predicts every output; one
// process compares DUT against model at each falling clock edge. Directed
// sequences add literal expectations, then random button activity follows.
module tb_game_round_ctrl;

    localparam int TickDiv   = 4;
    localparam int RoundTime = 3;
    localparam int Lives     = 2;

    localparam int PhIdle   = 0;
    localparam int PhNew    = 1;
    localparam int PhPlay   = 2;
    localparam int PhResult = 3;
    localparam int PhOver   = 4;

    logic       clk;
    logic       rst_n;
    logic       start_btn;
    logic       submit_btn;
    logic       match;
    logic [3:0] target;
    logic [7:0] score;
    logic [1:0] lives;
    logic [3:0] time_left;
    logic       playing;
    logic       round_won;
    logic       game_over;

    int errors = 0;
    int checks = 0;

    game_round_ctrl #(
        .TICK_DIV   (TickDiv),
        .ROUND_TIME (RoundTime),
        .LIVES      (Lives)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_btn  (start_btn),
        .submit_btn (submit_btn),
        .match      (match),
        .target     (target),
        .score      (score),
        .lives      (lives),
        .time_left  (time_left),
        .playing    (playing),
        .round_won  (round_won),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int        m_phase;
    int        m_target;
    int        m_score;
    int        m_lives;
    int        m_time;
    int        m_play_cyc;
    bit        m_won;
    bit        m_sq;
    bit        m_bq;
    logic [7:0] m_lfsr;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit se, be, tk;
        int ph, tg, sc, lv, tm, pc, nx;
        bit wn;
        if (!rst_n) begin
            m_phase    <= PhIdle;
            m_target   <= 0;
            m_score    <= 0;
            m_lives    <= 0;
            m_time     <= 0;
            m_play_cyc <= 0;
            m_won      <= 1'b0;
            m_sq       <= 1'b1;
            m_bq       <= 1'b1;
            m_lfsr     <= 8'hA5;
        end else begin
            se = start_btn && !m_sq;
            be = submit_btn && !m_bq;
            ph = m_phase; tg = m_target; sc = m_score; lv = m_lives;
            tm = m_time;  pc = m_play_cyc;
            wn = 1'b0;
            case (ph)
                PhIdle, PhOver: begin
                    if (se) begin
                        sc = 0;
                        lv = Lives;
                        ph = PhNew;
                    end
                end
                PhNew: begin
                    nx = int'(m_lfsr[3:0]);
                    if (nx == tg) nx = (nx + 1) % 16;
                    tg = nx;
                    tm = RoundTime;
                    pc = 0;
                    ph = PhPlay;
                end
                PhPlay: begin
                    // A second elapses on every TickDiv-th cycle spent in play.
                    tk = ((pc % TickDiv) == TickDiv - 1);
                    pc = pc + 1;
                    if (be) begin
                        if (match) begin
                            if (sc < 255) sc = sc + 1;
                            wn = 1'b1;
                        end else begin
                            lv = lv - 1;
                        end
                        ph = PhResult;
                    end else if (tk) begin
                        tm = tm - 1;
                        if (tm == 0) begin
                            lv = lv - 1;
                            ph = PhResult;
                        end
                    end
                end
                PhResult: ph = (lv == 0) ? PhOver : PhNew;
                default: ph = PhIdle;
            endcase
            m_phase    <= ph;
            m_target   <= tg;
            m_score    <= sc;
            m_lives    <= lv;
            m_time     <= tm;
            m_play_cyc <= pc;
            m_won      <= wn;
            m_sq       <= start_btn;
            m_bq       <= submit_btn;
            m_lfsr     <= lfsr_next(m_lfsr);
        end
    end

    // ---------------- continuous compare ----------------
    always @(negedge clk) begin
        chk("target",    int'(target),    m_target);
        chk("score",     int'(score),     m_score);
        chk("lives",     int'(lives),     m_lives);
        chk("time_left", int'(time_left), m_time);
        chk("playing",   int'(playing),   int'(m_phase == PhPlay));
        chk("round_won", int'(round_won), int'(m_won));
        chk("game_over", int'(game_over), int'(m_phase == PhOver));
    end

    // ---------------- helpers ----------------
    task automatic wait_play(input int budget);
        int n;
        n = 0;
        while (m_phase != PhPlay && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (m_phase != PhPlay) begin
            checks++;
            errors++;
            $display("FAIL wait_play: got phase %0d expected %0d within %0d cycles",
                     m_phase, PhPlay, budget);
        end
    endtask

    task automatic pulse_submit(input logic m);
        submit_btn = 1'b1;
        match      = m;
        @(negedge clk);
        submit_btn = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int prev_t, s_sav, l_sav, n;
        start_btn  = 1'b0;
        submit_btn = 1'b0;
        match      = 1'b0;
        rst_n      = 1'b1;
        #1 rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_target", int'(target), 0);
        chk("rst_lives",  int'(lives), 0);
        chk("rst_time",   int'(time_left), 0);
        chk("rst_play",   int'(playing), 0);

        #2 rst_n = 1'b1;
        @(negedge clk);                 // first edge: LFSR A5 -> 4A
        start_btn = 1'b1;
        @(negedge clk);                 // start edge: LFSR -> 95, new round next
        chk("new_round_not_playing", int'(playing), 0);
        @(negedge clk);
        chk("first_target", int'(target), 5);
        chk("first_lives",  int'(lives), 2);
        chk("first_time",   int'(time_left), 3);
        chk("first_score",  int'(score), 0);
        chk("first_play",   int'(playing), 1);
        start_btn = 1'b0;

        // Timeout: one second per 4 play cycles, life lost on cycle 12.
        repeat (3) @(negedge clk);
        chk("cd_hold", int'(time_left), 3);
        @(negedge clk);
        chk("cd_2", int'(time_left), 2);
        repeat (8) @(negedge clk);
        chk("to_lives", int'(lives), 1);
        chk("to_time",  int'(time_left), 0);
        chk("to_play",  int'(playing), 0);
        repeat (2) @(negedge clk);
        chk("to_next_time", int'(time_left), 3);
        chk("to_next_play", int'(playing), 1);

        // Correct submit.
        prev_t     = m_target;
        submit_btn = 1'b1;
        match      = 1'b1;
        @(negedge clk);
        chk("win_pulse", int'(round_won), 1);
        chk("win_score", int'(score), 1);
        chk("win_lives", int'(lives), 1);
        submit_btn = 1'b0;
        match      = 1'b0;
        @(negedge clk);
        chk("win_pulse_end", int'(round_won), 0);
        @(negedge clk);
        chk("no_repeat", int'(int'(target) != prev_t), 1);
        chk("win_next_time", int'(time_left), 3);

        // Wrong submit on last life -> game over; submits then do nothing.
        submit_btn = 1'b1;
        @(negedge clk);
        submit_btn = 1'b0;
        @(negedge clk);
        chk("over_flag",  int'(game_over), 1);
        chk("over_lives", int'(lives), 0);
        pulse_submit(1'b1);
        pulse_submit(1'b0);
        chk("over_hold_score", int'(score), 1);
        chk("over_hold_flag",  int'(game_over), 1);

        start_btn = 1'b1;
        repeat (2) @(negedge clk);
        start_btn = 1'b0;
        chk("restart_play",  int'(playing), 1);
        chk("restart_lives", int'(lives), 2);
        chk("restart_score", int'(score), 0);

        // Submit coinciding with the final tick counts as a win.
        n = 0;
        while (!(m_phase == PhPlay && m_time == 1 && (m_play_cyc % TickDiv) == TickDiv - 1)
               && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("final_tick_reached", n < 40 ? 1 : 0, 1);
        s_sav      = m_score;
        l_sav      = m_lives;
        submit_btn = 1'b1;
        match      = 1'b1;
        @(negedge clk);
        submit_btn = 1'b0;
        chk("tie_score", int'(score), s_sav + 1);
        chk("tie_lives", int'(lives), l_sav);
        chk("tie_time",  int'(time_left), 1);
        chk("tie_won",   int'(round_won), 1);

        // Drive the score up to saturation with wins.
        n = 0;
        while (m_score < 255 && n < 300) begin
            wait_play(10);
            pulse_submit(1'b1);
            n++;
        end
        wait_play(10);
        submit_btn = 1'b1;
        match      = 1'b1;
        @(negedge clk);
        submit_btn = 1'b0;
        chk("sat_score", int'(score), 255);
        chk("sat_won",   int'(round_won), 1);

        // Random activity.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            submit_btn = ($urandom_range(0, 3) == 0);
            match      = 1'($urandom_range(0, 1));
            start_btn  = ($urandom_range(0, 15) == 0);
        end

        // Start held through reset release gives no edge.
        start_btn  = 1'b1;
        submit_btn = 1'b0;
        #2 rst_n   = 1'b0;
        @(negedge clk);
        #2 rst_n   = 1'b1;
        repeat (5) @(negedge clk);
        chk("held_start_idle_play", int'(playing), 0);
        chk("held_start_idle_over", int'(game_over), 0);
        chk("held_start_lives",     int'(lives), 0);

        start_btn = 1'b0;
        @(negedge clk);
        start_btn = 1'b1;
        wait_play(10);
        start_btn = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_target", int'(target), 0);
        chk("async_score",  int'(score), 0);
        chk("async_lives",  int'(lives), 0);
        chk("async_time",   int'(time_left), 0);
        chk("async_play",   int'(playing), 0);
        chk("async_over",   int'(game_over), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
